sap_1_loader: RTL and testbench

Program loader for the SAP-1 core: the writer side of the SAP-1 program RAM that the core reads while it executes. It takes bytes one at a time from the input switches, qualified by a strobe pin, writes them to RAM at consecutive addresses, and holds the core in reset until a run request releases it. It sits between the top-level pin wrapper (switches and bidirectional pins) and the `sap_1` core's RAM write port and reset input.

---
 rtl/sap_1_loader.sv | 97 +++++++++
 tb/tb_sap_1_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sap_1_loader.sv
// sap_1_loader: SAP-1 program loader; optional checksum byte via SAP1_LOADER_CHECKSUM_EN.
module sap_1_loader #(
  parameter int ADDR_W = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data_in,
  input  logic              strobe,
  input  logic              run_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              cpu_rst,
  output logic              loading,
  output logic              done,
  output logic              err
);
`ifdef SAP1_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {LOAD, READY, RUN, ERR} state_t;
  logic [7:0] sum;
`else
  typedef enum logic [1:0] {LOAD, READY, RUN} state_t;
`endif
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] stb_sync, run_sync;
  logic stb_prev, run_prev, stb_edge, run_edge, we_nx;
  logic [ADDR_W:0] count, count_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_sync <= '0;
      run_sync <= '0;
      stb_prev <= 1'b0;
      run_prev <= 1'b0;
      stb_edge <= 1'b0;
      run_edge <= 1'b0;
      state <= LOAD;
      count <= '0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      cpu_rst <= 1'b1;
`ifdef SAP1_LOADER_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], strobe};
      run_sync <= {run_sync[SYNC_STAGES-2:0], run_req};
      stb_prev <= stb_sync[SYNC_STAGES-1];
      run_prev <= run_sync[SYNC_STAGES-1];
      stb_edge <= stb_sync[SYNC_STAGES-1] & ~stb_prev;
      run_edge <= run_sync[SYNC_STAGES-1] & ~run_prev;
      state <= state_nx;
      count <= count_nx;
      ram_we <= we_nx;
      // cpu_rst lags the state so the final write lands before the core runs
      cpu_rst <= state != RUN;
      if (we_nx) begin
        ram_addr <= count[ADDR_W-1:0];
        ram_wdata <= data_in;
`ifdef SAP1_LOADER_CHECKSUM_EN
        sum <= sum + data_in;
`endif
      end
    end
  end
  always_comb begin
    state_nx = state;
    count_nx = count;
    we_nx = 1'b0;
`ifdef SAP1_LOADER_CHECKSUM_EN
    if (state == LOAD && stb_edge) begin
      if (count == {1'b1, {ADDR_W{1'b0}}})
        state_nx = (data_in == sum) ? READY : ERR;
      else begin
        we_nx = 1'b1;
        count_nx = count + 1'b1;
      end
    end
    if (state == READY && run_edge) state_nx = RUN;
`else
    if (state == LOAD && stb_edge) begin
      we_nx = 1'b1;
      count_nx = count + 1'b1;
      if (count == {1'b0, {ADDR_W{1'b1}}}) state_nx = READY;
    end
    if ((state == LOAD || state == READY) && run_edge) state_nx = RUN;
`endif
  end
  assign loading = state == LOAD;
  assign done = state == READY;
`ifdef SAP1_LOADER_CHECKSUM_EN
  assign err = state == ERR;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_sap_1_loader.sv
// tb_sap_1_loader: directed table-driven bench for sap_1_loader (default parameters).
module tb_sap_1_loader;
  logic clk = 1'b0, rst = 1'b0, strobe = 1'b0, run_req = 1'b0;
  logic [7:0] data_in = '0;
  logic ram_we, cpu_rst, loading, done, err;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  int checks = 0, failures = 0, bad_we = 0;
  typedef struct {logic [7:0] d; int n; logic [3:0] a;} vec_t;
  vec_t tbl[17];

  sap_1_loader dut (
    .clk(clk), .rst(rst), .data_in(data_in), .strobe(strobe), .run_req(run_req),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .cpu_rst(cpu_rst),
    .loading(loading), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (ram_we && !cpu_rst) bad_we++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; strobe = 1'b0; run_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output int n, output logic [3:0] a, output logic [7:0] w);
    n = 0; a = '0; w = '0;
    data_in = d;
    @(negedge clk);
    strobe = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ram_we) begin n++; a = ram_addr; w = ram_wdata; end
      if (i == 3) strobe = 1'b0;
    end
  endtask

  task automatic pulse_run();
    @(negedge clk);
    run_req = 1'b1;
    repeat (4) @(negedge clk);
    run_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n, ld_k, cr_k, we_k;
    logic [3:0] a;
    logic [7:0] w, mask;
    for (int i = 0; i < 16; i++) tbl[i] = '{8'(i), 1, 4'(i)};
    tbl[16] = '{8'h77, 0, 4'h0};

    do_reset();
    chk("reset_outputs", {ram_we, ram_addr, ram_wdata, cpu_rst, loading, done, err}, {1'b0, 4'h0, 8'h00, 4'b1100});

    // strobe rises before posedge 0; write must appear only after posedge 3
    @(negedge clk);
    data_in = 8'hA5; strobe = 1'b1; mask = '0; a = '0; w = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ram_we) begin mask[k] = 1'b1; a = ram_addr; w = ram_wdata; end
      if (k == 3) strobe = 1'b0;
    end
    chk("latency_mask", mask, 8'h08);
    chk("latency_addr", a, 4'h0);
    chk("latency_data", w, 8'hA5);

    do_reset();
`ifndef SAP1_LOADER_CHECKSUM_EN
    for (int i = 0; i < 17; i++) begin
      send_byte(tbl[i].d, n, a, w);
      chk($sformatf("fill_we_count[%0d]", i), n, tbl[i].n);
      if (tbl[i].n != 0) begin
        chk($sformatf("fill_addr[%0d]", i), a, tbl[i].a);
        chk($sformatf("fill_data[%0d]", i), w, tbl[i].d);
      end
    end
    chk("full_done", done, 1'b1);
    chk("full_loading", loading, 1'b0);
    chk("full_cpu_rst", cpu_rst, 1'b1);

    // partial load then run
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i), n, a, w);
    chk("partial_last_addr", a, 4'h2);
    @(negedge clk);
    run_req = 1'b1; ld_k = -1; cr_k = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!loading && ld_k < 0) ld_k = k;
      if (!cpu_rst && cr_k < 0) cr_k = k;
      if (k == 3) run_req = 1'b0;
    end
    chk("run_state_cycle", ld_k, 3);
    chk("run_cpu_rst_cycle", cr_k, 4);
    chk("run_done", done, 1'b0);
    send_byte(8'hEE, n, a, w);
    chk("run_strobe_ignored", n, 0);
    pulse_run();
    chk("run_stays_run", {cpu_rst, loading, done}, 3'b000);

    // strobe and run together on byte 5
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(8'(i), n, a, w);
    @(negedge clk);
    data_in = 8'h5C; strobe = 1'b1; run_req = 1'b1; we_k = -1; cr_k = -1; a = '0; w = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ram_we && we_k < 0) begin we_k = k; a = ram_addr; w = ram_wdata; end
      if (!cpu_rst && cr_k < 0) cr_k = k;
      if (k == 3) begin strobe = 1'b0; run_req = 1'b0; end
    end
    chk("both_we_cycle", we_k, 3);
    chk("both_addr", a, 4'h5);
    chk("both_data", w, 8'h5C);
    chk("both_cpu_rst_cycle", cr_k, 4);
`endif

    // reset mid-load
    do_reset();
    for (int i = 0; i < 7; i++) send_byte(8'h40 + 8'(i), n, a, w);
    chk("midload_last_addr", a, 4'h6);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midload_count", dut.count, 0);
    chk("midload_status", {loading, cpu_rst, done}, 3'b110);
    send_byte(8'h99, n, a, w);
    chk("midload_rewrite_count", n, 1);
    chk("midload_rewrite_addr", a, 4'h0);

`ifdef SAP1_LOADER_CHECKSUM_EN
    do_reset();
    for (int i = 0; i < 16; i++) send_byte(8'h01, n, a, w);
    chk("cs_16th_addr", a, 4'hF);
    chk("cs_not_done_before_sum", done, 1'b0);
    pulse_run();
    chk("cs_run_in_load_ignored", {cpu_rst, loading}, 2'b11);
    send_byte(8'h10, n, a, w);
    chk("cs_good_no_write", n, 0);
    chk("cs_good_status", {done, err, loading}, 3'b100);
    pulse_run();
    chk("cs_good_run", cpu_rst, 1'b0);

    do_reset();
    for (int i = 0; i < 16; i++) send_byte(8'h01, n, a, w);
    send_byte(8'h11, n, a, w);
    chk("cs_bad_no_write", n, 0);
    chk("cs_bad_status", {err, done, loading, cpu_rst}, 4'b1001);
    pulse_run();
    chk("cs_bad_run_ignored", {err, cpu_rst}, 2'b11);
    send_byte(8'h22, n, a, w);
    chk("cs_bad_strobe_ignored", n, 0);
`endif

    chk("we_while_cpu_running", bad_we, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
